// File: rtl/imm32_pkg.sv
// imm32_pkg: shared constants and types for the RV32I immediate generator.
// Holds the opcode encodings, the immediate-format code and XLEN.
package imm32_pkg;

  localparam int XLEN = 32;

  // RV32I major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;

  // Immediate format reported alongside the immediate
  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_t;

endpackage

// File: rtl/imm32_ext.sv
// imm32_ext: combinational immediate extraction and extension.
// Maps an instruction word plus the extension select to the next
// immediate value and its format code. No state.
module imm32_ext
  import imm32_pkg::*;
(
  input  logic [31:0]     i_in,
  input  logic            i_signextend,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_t        o_fmt
);

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_s;

  assign w_op = i_in[6:0];
  assign w_f3 = i_in[14:12];
  // Every signed RV32I immediate keeps its MSB in in[31], so one fill bit
  // serves I/S/B/J alike; zero-extension simply forces it low.
  assign w_s  = i_signextend & i_in[31];

  // Opcode decode and field reassembly
  always_comb begin
    o_imm = '0;
    o_fmt = FMT_NONE;
    case (w_op)
      OP_IMM: begin
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          // shift amount is unsigned regardless of the extension select
          o_fmt = FMT_SHAMT;
          o_imm = {27'b0, i_in[24:20]};
        end else begin
          o_fmt = FMT_I;
          o_imm = {{20{w_s}}, i_in[31:20]};
        end
      end
      LOAD, JALR, SYSTEM: begin
        o_fmt = FMT_I;
        o_imm = {{20{w_s}}, i_in[31:20]};
      end
      STORE: begin
        o_fmt = FMT_S;
        o_imm = {{20{w_s}}, i_in[31:25], i_in[11:7]};
      end
      BRANCH: begin
        o_fmt = FMT_B;
        o_imm = {{19{w_s}}, i_in[31], i_in[7], i_in[30:25], i_in[11:8], 1'b0};
      end
      LUI, AUIPC: begin
        o_fmt = FMT_U;
        o_imm = {i_in[31:12], 12'b0};
      end
      JAL: begin
        o_fmt = FMT_J;
        o_imm = {{11{w_s}}, i_in[31], i_in[19:12], i_in[20], i_in[30:21], 1'b0};
      end
      default: begin
        o_fmt = FMT_NONE;
        o_imm = '0;
      end
    endcase
  end

endmodule

// File: rtl/imm32_gen.sv
// imm32_gen: RV32I immediate generator with one cycle of latency.
// Decode lives in imm32_ext; this level only registers the result.
// Optional macro IMM32_GEN_ILLEGAL_EN adds a registered 'illegal' flag.
module imm32_gen
  import imm32_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     in,
  input  logic            signextend,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt
`ifdef IMM32_GEN_ILLEGAL_EN
  ,
  output logic            illegal
`endif
);

  logic [XLEN-1:0] w_imm;
  imm_fmt_t        w_fmt;
  logic [XLEN-1:0] r_imm;
  imm_fmt_t        r_fmt;

  imm32_ext u_ext (
    .i_in        (in),
    .i_signextend(signextend),
    .o_imm       (w_imm),
    .o_fmt       (w_fmt)
  );

  // Capture decoded immediate and format every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_imm <= '0;
      r_fmt <= FMT_NONE;
    end else begin
      r_imm <= w_imm;
      r_fmt <= w_fmt;
    end
  end

  assign imm = r_imm;
  assign fmt = r_fmt;

`ifdef IMM32_GEN_ILLEGAL_EN
  logic r_illegal;

  // Every supported opcode ends in 2'b11, so in[1:0] != 2'b11 already
  // lands in the NONE decode; one compare covers both illegal cases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_illegal <= 1'b0;
    else       r_illegal <= (w_fmt == FMT_NONE);
  end

  assign illegal = r_illegal;
`endif

endmodule

// File: tb/tb_imm32_gen.sv
// tb_imm32_gen: directed and randomized check of imm32_gen against a
// field-arithmetic reference model.
module tb_imm32_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in;
  logic        signextend;
  logic [31:0] imm;
  logic [2:0]  fmt;
`ifdef IMM32_GEN_ILLEGAL_EN
  logic        illegal;
`endif

  int vectors = 0;
  int miscompares = 0;

  imm32_gen dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .signextend(signextend),
    .imm       (imm),
    .fmt       (fmt)
`ifdef IMM32_GEN_ILLEGAL_EN
    ,
    .illegal   (illegal)
`endif
  );

  always #5 clk = ~clk;

  // Reference: pull the immediate out as an integer from its bit fields,
  // then interpret it as a w-bit two's-complement number when signed.
  function automatic logic [34:0] ref_model(input logic [31:0] x, input logic se);
    longint unsigned op, f3, raw, span;
    longint          val;
    int              w, f;
    logic [31:0]     r32;
    op = longint'(x & 32'h7F);
    f3 = longint'((x >> 12) & 32'h7);
    w = 0; f = 0; raw = 0;
    case (op)
      64'h13: begin
        if (f3 == 1 || f3 == 5) begin
          r32 = (x >> 20) & 32'h1F;
          return {3'd6, r32};
        end
        f = 1; w = 12; raw = longint'(x >> 20);
      end
      64'h03, 64'h67, 64'h73: begin f = 1; w = 12; raw = longint'(x >> 20); end
      64'h23: begin
        f = 2; w = 12;
        raw = (longint'(x >> 25) * 32) + longint'((x >> 7) & 32'h1F);
      end
      64'h63: begin
        f = 3; w = 13;
        raw = longint'(x >> 31) * 4096 + longint'((x >> 7) & 1) * 2048
            + longint'((x >> 25) & 32'h3F) * 32 + longint'((x >> 8) & 32'hF) * 2;
      end
      64'h37, 64'h17: begin
        r32 = x & 32'hFFFFF000;
        return {3'd4, r32};
      end
      64'h6F: begin
        f = 5; w = 21;
        raw = longint'(x >> 31) * (1 << 20) + longint'((x >> 12) & 32'hFF) * 4096
            + longint'((x >> 20) & 1) * 2048 + longint'((x >> 21) & 32'h3FF) * 2;
      end
      default: return 35'd0;
    endcase
    span = longint'(1) << w;
    raw = raw % span;
    val = longint'(raw);
    if (se && raw >= span / 2) val = val - longint'(span);
    r32 = val[31:0];
    return {f[2:0], r32};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] x, input logic se);
    logic [34:0] r;
    r = ref_model(x, se);
    check({tag, ".imm"}, imm, r[31:0]);
    check({tag, ".fmt"}, {29'd0, fmt}, {29'd0, r[34:32]});
`ifdef IMM32_GEN_ILLEGAL_EN
    check({tag, ".illegal"}, {31'd0, illegal}, {31'd0, (r[34:32] == 3'd0)});
`endif
  endtask

  // Drive between edges, then sample just after the capturing edge
  task automatic apply(input string tag, input logic [31:0] x, input logic se);
    @(negedge clk);
    in = x;
    signextend = se;
    @(posedge clk);
    #1;
    check_out(tag, x, se);
  endtask

  logic [31:0] vecs [9];
  logic [6:0]  ops  [9];

  initial begin
    vecs = '{32'hFFF00093, 32'h00000073, 32'hFE20AE23, 32'hFE000CE3, 32'h123450B7,
             32'h0010006F, 32'h01F09093, 32'h0000007F, 32'h80000017};
    ops  = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    // Reset with a live instruction present, no clock edge yet
    reset = 1'b1;
    in = 32'hFFF00093;
    signextend = 1'b1;
    #1;
    check("reset.imm", imm, 32'h0);
    check("reset.fmt", {29'd0, fmt}, 32'd0);
`ifdef IMM32_GEN_ILLEGAL_EN
    check("reset.illegal", {31'd0, illegal}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors with explicit expectations
    apply("ecall", 32'h00000073, 1'b1);
    check("ecall.lit", imm, 32'h0);
    apply("i_se1", 32'hFFF00093, 1'b1);
    check("i_se1.lit", imm, 32'hFFFFFFFF);
    apply("i_se0", 32'hFFF00093, 1'b0);
    check("i_se0.lit", imm, 32'h00000FFF);
    apply("sw", 32'hFE20AE23, 1'b1);
    check("sw.lit", imm, 32'hFFFFFFFC);
    apply("beq", 32'hFE000CE3, 1'b1);
    check("beq.lit", imm, 32'hFFFFFFF8);
    apply("lui1", 32'h123450B7, 1'b1);
    check("lui1.lit", imm, 32'h12345000);
    apply("lui0", 32'h123450B7, 1'b0);
    check("lui0.lit", imm, 32'h12345000);
    apply("jal", 32'h0010006F, 1'b1);
    check("jal.lit", imm, 32'h00000800);
    apply("slli", 32'h01F09093, 1'b1);
    check("slli.lit", imm, 32'h0000001F);
    apply("srai_se", 32'hFFF0D093, 1'b1);
    apply("unk", 32'h0000007F, 1'b1);
    check("unk.lit", {29'd0, fmt}, 32'd0);
    apply("lo_bits", 32'hFFF00090, 1'b1);
    apply("jal_neg", 32'hFFDFF06F, 1'b1);
    apply("jal_neg0", 32'hFFDFF06F, 1'b0);

    // Back-to-back: a new word every cycle, each result one edge later
    for (int i = 0; i < 9; i++) apply("b2b", vecs[i], i[0]);

    // Mid-stream reset between edges clears outputs without a clock
    apply("pre_rst", 32'hFE20AE23, 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst.imm", imm, 32'h0);
    check("mid_rst.fmt", {29'd0, fmt}, 32'd0);
    in = 32'h0010006F;
    signextend = 1'b1;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_out("post_rst", 32'h0010006F, 1'b1);

    // Randomized: mostly valid opcodes with random fields, some junk
    for (int i = 0; i < 300; i++) begin
      logic [31:0] x;
      x = $urandom;
      if ($urandom_range(3) != 0) x[6:0] = ops[$urandom_range(8)];
      apply("rand", x, 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
